wb_spi: RTL and testbench



---
 rtl/wb_spi_pkg.sv | 23 ++
 rtl/spi_shift_engine.sv | 99 +++++++++
 rtl/wb_spi.sv | 111 +++++++++++
 tb/tb_wb_spi.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_pkg.sv
// Shared constants for the Wishbone SPI master: register word offsets,
// shift-engine state encoding and STATUS bit positions.
package wb_spi_pkg;

  // Register offsets as word indices (wb_adr_i[3:2])
  localparam logic [1:0] SPI_DATA   = 2'd0;
  localparam logic [1:0] SPI_STATUS = 2'd1;
  localparam logic [1:0] SPI_DIV    = 2'd2;
  localparam logic [1:0] SPI_CS     = 2'd3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_RXV  = 1;
  localparam int unsigned STAT_IEN  = 2;

  localparam logic [3:0] FRAME_BITS = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_TRAIL
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI shift engine: half-period divider, 8-bit MSB-first shifter,
// MISO two-flop synchroniser and the IDLE/LEAD/TRAIL sequencer.
module spi_shift_engine
  import wb_spi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  tx_byte_i,
  input  logic [15:0] divisor_i,
  input  logic        miso_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rx_byte_o,
  output logic        sck_o,
  output logic        mosi_o
);

  spi_state_e  state_q;
  logic [15:0] cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        sck_q;
  logic        mosi_q;
  logic        busy_q;
  logic [1:0]  miso_sync_q;
  logic        half_end;

  assign half_end = (cnt_q == divisor_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miso_sync_q <= '0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], miso_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            shift_q   <= tx_byte_i;
            mosi_q    <= tx_byte_i[7];
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (half_end) begin
            sck_q     <= 1'b1;
            shift_q   <= {shift_q[6:0], miso_sync_q[1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            cnt_q     <= '0;
            state_q   <= ST_TRAIL;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_TRAIL: begin
          if (half_end) begin
            sck_q <= 1'b0;
            cnt_q <= '0;
            if (bit_cnt_q == FRAME_BITS) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              // After the shift, bit 7 already holds the next bit to send
              mosi_q  <= shift_q[7];
              state_q <= ST_LEAD;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Completion strobe: high in the cycle whose closing edge ends the frame
  assign done_o    = (state_q == ST_TRAIL) && half_end && (bit_cnt_q == FRAME_BITS);
  assign rx_byte_o = shift_q;
  assign busy_o    = busy_q;
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;

endmodule

// File: rtl/wb_spi.sv
// Wishbone classic-cycle slave exposing an SPI master: DATA/STATUS/DIVISOR/CS
// registers, single-cycle ack, and a level interrupt on received bytes.
module wb_spi
  import wb_spi_pkg::*;
#(
  parameter logic [15:0] div_reset = 16'd49
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        intr,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [7:0]  spi_cs_n
);

  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rd_data_d;
  logic [15:0] div_q;
  logic [7:0]  cs_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        ien_q;

  logic        access;
  logic        wr;
  logic        rd;
  logic [1:0]  reg_sel;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  rx_byte;

  logic        unused_bits;
  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i, wb_dat_i[31:16]};

  assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr      = access & wb_we_i;
  assign rd      = access & ~wb_we_i;
  assign reg_sel = wb_adr_i[3:2];
  assign start   = wr && (reg_sel == SPI_DATA) && !busy;

  spi_shift_engine u_engine (
    .clk_i     (clk),
    .rst_ni    (rst),
    .start_i   (start),
    .tx_byte_i (wb_dat_i[7:0]),
    .divisor_i (div_q),
    .miso_i    (spi_miso),
    .busy_o    (busy),
    .done_o    (done),
    .rx_byte_o (rx_byte),
    .sck_o     (spi_sck),
    .mosi_o    (spi_mosi)
  );

  always_comb begin
    rd_data_d = '0;
    case (reg_sel)
      SPI_DATA:   rd_data_d = {24'd0, rx_data_q};
      SPI_STATUS: begin
        rd_data_d[STAT_BUSY] = busy;
        rd_data_d[STAT_RXV]  = rx_valid_q;
        rd_data_d[STAT_IEN]  = ien_q;
      end
      SPI_DIV:    rd_data_d = {16'd0, div_q};
      SPI_CS:     rd_data_d = {24'd0, cs_q};
      default:    rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      div_q      <= div_reset;
      cs_q       <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ien_q      <= 1'b0;
    end else begin
      ack_q <= access;
      if (rd) dat_q <= rd_data_d;
      if (wr && (reg_sel == SPI_STATUS)) ien_q <= wb_dat_i[STAT_IEN];
      if (wr && (reg_sel == SPI_DIV) && !busy) div_q <= wb_dat_i[15:0];
      if (wr && (reg_sel == SPI_CS)) cs_q <= wb_dat_i[7:0];
      // A completing frame outranks a concurrent DATA read's clear
      if (done) begin
        rx_data_q  <= rx_byte;
        rx_valid_q <= 1'b1;
      end else if (rd && (reg_sel == SPI_DATA)) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign spi_cs_n = cs_q;
  assign intr     = rx_valid_q & ien_q;

endmodule

// File: tb/tb_wb_spi.sv
// Self-checking bench for wb_spi: directed register/timing scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_wb_spi;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_DIV  = 4'h8;
  localparam logic [3:0] A_CS   = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_ack_o;
  logic        intr;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic [7:0]  spi_cs_n;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc_n    = 0;
  int unsigned t0       = 0;

  bit          loopback = 1'b1;
  logic [7:0]  slave_sr = '0;
  logic        sck_prev = 1'b0;
  logic [7:0]  mosi_cap = '0;
  int unsigned rise_q[$];
  int unsigned fall_q[$];

  wb_spi #(.div_reset(16'd49)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (4'hF),
    .wb_we_i  (wb_we),
    .wb_stb_i (wb_stb),
    .wb_cyc_i (wb_cyc),
    .wb_ack_o (wb_ack_o),
    .intr     (intr),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  assign spi_miso = loopback ? spi_mosi : slave_sr[7];

  // Slave model: presents next bit after each SCK fall (mode 0)
  always @(negedge spi_sck) slave_sr = {slave_sr[6:0], 1'b0};

  // SCK edge recorder, sampled on the falling clock edge
  always @(negedge clk) begin
    if (spi_sck && !sck_prev) begin
      rise_q.push_back(cyc_n);
      mosi_cap = {mosi_cap[6:0], spi_mosi};
    end
    if (!spi_sck && sck_prev) fall_q.push_back(cyc_n);
    sck_prev = spi_sck;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack();
    int unsigned k = 0;
    do begin
      tick();
      k++;
    end while (!wb_ack_o && k < 8);
    if (!wb_ack_o) chk("wb_ack_timeout", {31'd0, wb_ack_o}, 32'd1);
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
    wb_adr = {28'd0, off};
    wb_dat = d;
    wb_we  = 1'b1;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wait_ack();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
    wb_adr = {28'd0, off};
    wb_we  = 1'b0;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wait_ack();
    d = wb_dat_o;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(off, d);
    chk(tag, d, exp);
  endtask

  task automatic start_frame(input logic [7:0] tx, input bit lb, input logic [7:0] sb);
    loopback = lb;
    slave_sr = sb;
    rise_q.delete();
    fall_q.delete();
    mosi_cap = '0;
    wb_write(A_DATA, {24'd0, tx});
    t0 = cyc_n;
  endtask

  // Expected: 8 pulses, every half-period (div+1) cycles, first rise (div+1) after start
  task automatic check_sck(input int unsigned div, input logic [7:0] exp_mosi);
    int unsigned h = div + 1;
    int unsigned bad = 0;
    chk("sck_rises", rise_q.size(), 8);
    chk("sck_falls", fall_q.size(), 8);
    if (rise_q.size() == 8 && fall_q.size() == 8) begin
      if (rise_q[0] - t0 != h) bad++;
      for (int i = 0; i < 8; i++) begin
        if (fall_q[i] - rise_q[i] != h) bad++;
        if (i < 7 && rise_q[i+1] - fall_q[i] != h) bad++;
      end
    end
    chk("sck_timing", bad, 0);
    chk("mosi_bits", {24'd0, mosi_cap}, {24'd0, exp_mosi});
  endtask

  task automatic wait_done(input int unsigned div, input logic [7:0] exp_mosi);
    int unsigned len = 16 * (div + 1);
    int unsigned k = 0;
    while (!intr && k < len + 8) begin
      tick();
      k++;
    end
    chk("frame_len", cyc_n - t0, len);
    tick();
    check_sck(div, exp_mosi);
  endtask

  initial begin
    logic [31:0] d;
    int unsigned k;
    int unsigned div;
    logic [7:0]  tx;
    logic [7:0]  sb;
    bit          lb;

    // Reset
    tick();
    tick();
    chk("rst_cs_n", {24'd0, spi_cs_n}, 32'hFF);
    chk("rst_sck", {31'd0, spi_sck}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_intr", {31'd0, intr}, 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    rst = 1'b1;
    tick();
    read_chk("rst_div", A_DIV, 32'd49);
    read_chk("rst_status", A_STAT, 32'd0);

    // Loopback at DIVISOR=3
    wb_write(A_STAT, 32'h4);
    read_chk("ien_set", A_STAT, 32'h4);
    wb_write(A_DIV, 32'd3);
    read_chk("div_rw", A_DIV, 32'd3);
    start_frame(8'hA5, 1'b1, 8'h00);
    wait_done(3, 8'hA5);
    read_chk("lb_status_rxv", A_STAT, 32'h6);
    read_chk("lb_data", A_DATA, 32'hA5);
    read_chk("lb_status_clr", A_STAT, 32'h4);

    // External slave at DIVISOR=2
    wb_write(A_DIV, 32'd2);
    start_frame(8'hC3, 1'b0, 8'h3C);
    wait_done(2, 8'hC3);
    read_chk("slave_data", A_DATA, 32'h3C);
    read_chk("slave_status", A_STAT, 32'h4);

    // Writes while busy
    wb_write(A_DIV, 32'd3);
    start_frame(8'h5A, 1'b1, 8'h00);
    repeat (6) tick();
    wb_write(A_DATA, 32'h11);
    wb_write(A_DIV, 32'd7);
    wb_write(A_CS, 32'hFE);
    chk("cs_mid_frame", {24'd0, spi_cs_n}, 32'hFE);
    read_chk("busy_status", A_STAT, 32'h5);
    wait_done(3, 8'h5A);
    read_chk("div_unchanged", A_DIV, 32'd3);
    wb_write(A_CS, 32'hFF);
    chk("cs_restore", {24'd0, spi_cs_n}, 32'hFF);

    // New frame while rx_valid=1, DATA read racing the completion edge
    chk("intr_pending", {31'd0, intr}, 32'd1);
    start_frame(8'h96, 1'b1, 8'h00);
    k = 0;
    while (cyc_n < t0 + 63 && k < 100) begin
      tick();
      k++;
    end
    wb_adr = {28'd0, A_DATA};
    wb_we  = 1'b0;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    tick();
    chk("race_ack", {31'd0, wb_ack_o}, 32'd1);
    chk("race_old_data", wb_dat_o, 32'h5A);
    chk("race_intr", {31'd0, intr}, 32'd1);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    tick();
    check_sck(3, 8'h96);
    read_chk("race_new_data", A_DATA, 32'h96);
    chk("race_intr_drop", {31'd0, intr}, 32'd0);

    // Randomized frames against the reference model
    for (int unsigned it = 0; it < 8; it++) begin
      div = $urandom_range(2, 5);
      tx  = 8'($urandom);
      sb  = 8'($urandom);
      lb  = 1'($urandom);
      wb_write(A_DIV, div);
      start_frame(tx, lb, sb);
      wait_done(div, tx);
      read_chk("rnd_status", A_STAT, 32'h6);
      read_chk("rnd_data", A_DATA, {24'd0, lb ? tx : sb});
    end

    // Reset mid-frame
    wb_write(A_CS, 32'h00);
    wb_write(A_DIV, 32'd3);
    start_frame(8'hFF, 1'b1, 8'h00);
    k = 0;
    while (rise_q.size() < 3 && k < 100) begin
      tick();
      k++;
    end
    chk("mid_rises_reached", rise_q.size(), 3);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_cs_n", {24'd0, spi_cs_n}, 32'hFF);
    chk("mid_rst_sck", {31'd0, spi_sck}, 32'd0);
    chk("mid_rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("mid_rst_intr", {31'd0, intr}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    read_chk("mid_rst_status", A_STAT, 32'd0);
    read_chk("mid_rst_div", A_DIV, 32'd49);
    read_chk("mid_rst_data", A_DATA, 32'd0);
    repeat (40) tick();
    chk("mid_rst_no_sck", rise_q.size(), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
